// File: rtl/seq_comp_pkg.sv
// ============================================================================
// Module   : seq_comp_pkg
// Purpose  : Shared types and result encodings for the sequential comparator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_comp_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-hot {L,E,G} result encodings, identical to the combinational cascade
    localparam logic [2:0] RES_LT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_GT   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

    // Anything that is not a legal one-hot result collapses to RES_NONE,
    // mirroring the default case of the combinational comparator.
    function automatic logic [2:0] res_filter(input logic [2:0] res);
        case (res)
            RES_LT, RES_EQ, RES_GT: res_filter = res;
            default:                res_filter = RES_NONE;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_comp_slice_cmp.sv
// ============================================================================
// Module   : slice_cmp
// Purpose  : Combinational unsigned compare of one N-bit operand slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slice_cmp #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt,
    output logic         gt
);

    // Equality is implied when neither lt nor gt is set
    assign lt = (a < b);
    assign gt = (a > b);

endmodule

`default_nettype wire

// File: rtl/seq_comp.sv
// ============================================================================
// Module   : seq_comp
// Purpose  : Multi-cycle magnitude comparator, one N-bit slice per clock,
//            carrying a one-hot {L,E,G} result with start/busy/done handshake.
//            Optional macro SEQ_COMP_EARLY_EXIT_EN: process slices MSB-first
//            and finish on the first unequal slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_comp
    import seq_comp_pkg::*;
#(
    parameter int N      = 4,
    parameter int SLICES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N*SLICES-1:0] ain,
    input  logic [N*SLICES-1:0] bin,
    input  logic                aL,
    input  logic                aE,
    input  logic                aG,
    output logic                busy,
    output logic                done,
    output logic                f1,
    output logic                f2,
    output logic                f3
);

    localparam int W    = N * SLICES;
    localparam int IDXW = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDXW-1:0] c_last_idx = IDXW'(SLICES - 1);

`ifdef SEQ_COMP_EARLY_EXIT_EN
    localparam logic [IDXW-1:0] c_first_idx = c_last_idx;
`else
    localparam logic [IDXW-1:0] c_first_idx = '0;
`endif

    state_t          r_state;
    logic [IDXW-1:0] r_idx;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [2:0]      r_res;
    logic [2:0]      r_f;
    logic            r_busy;
    logic            r_done;

    logic [N-1:0]    w_a_slice;
    logic [N-1:0]    w_b_slice;
    logic            w_lt;
    logic            w_gt;
    logic [2:0]      w_next_res;
    logic            w_last;
    logic [IDXW-1:0] w_next_idx;

    // Select the slice addressed by the current index
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int i = 0; i < SLICES; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_slice = r_a[i*N +: N];
                w_b_slice = r_b[i*N +: N];
            end
        end
    end

    slice_cmp #(
        .N (N)
    ) u_slice_cmp (
        .a  (w_a_slice),
        .b  (w_b_slice),
        .lt (w_lt),
        .gt (w_gt)
    );

    // Unequal slice overwrites the running result; equal slice keeps it
    assign w_next_res = w_lt ? RES_LT : (w_gt ? RES_GT : r_res);

`ifdef SEQ_COMP_EARLY_EXIT_EN
    // MSB-first: the first unequal slice decides, lower slices are irrelevant
    assign w_last     = (r_idx == '0) || w_lt || w_gt;
    assign w_next_idx = r_idx - 1'b1;
`else
    // LSB-first: higher slices overwrite, so all slices must be visited
    assign w_last     = (r_idx == c_last_idx);
    assign w_next_idx = r_idx + 1'b1;
`endif

    // Controller: handshake, operand capture, slice stepping and result latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= RES_NONE;
            r_f     <= RES_NONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= ain;
                        r_b     <= bin;
                        r_res   <= {aL, aE, aG};
                        r_idx   <= c_first_idx;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_res <= w_next_res;
                    if (w_last) begin
                        r_f     <= res_filter(w_next_res);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx <= w_next_idx;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign {f1, f2, f3} = r_f;

endmodule

`default_nettype wire

// File: doc/seq_comp.md
Name: seq_comp

Overview:
- Multi-cycle magnitude comparator for wide operands (N*SLICES bits), processing one N-bit slice per clock.
- Carries a one-hot {L,E,G} result from slice to slice in the same cascade format used by the team's combinational N-bit comparator.
- Feeds that comparator's cascade inputs (aL/aE/aG) or any consumer of f1/f2/f3.
- Start/busy/done handshake; the result is held until the next accepted start.

Parameters:
- N, 4, slice width in bits.
- SLICES, 4, number of slices; operand width W = N*SLICES; SLICES >= 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a compare; accepted only in IDLE or DONE.
- ain  input  W  operand A, unsigned; sampled on the accepting edge.
- bin  input  W  operand B, unsigned; sampled on the accepting edge.
- aL, aE, aG  input  1 each  cascade-in (less/equal/greater from a lower-order stage); sampled with the operands.
- busy  output  1  high while slices are being processed.
- done  output  1  one-cycle pulse when f1/f2/f3 become valid.
- f1, f2, f3  output  1 each  result: A<B / A==B / A>B.

Behaviour:
- Reset (async, rst=1): state=IDLE, slice index=0, busy=0, done=0, f1=f2=f3=0, internal L/E/G=000. Deasserting rst mid-operation leaves the block in IDLE; an in-flight compare is discarded with no done.
- States:
  - IDLE: start=1 -> latch ain, bin, {aL,aE,aG} into the running result; idx=0; go to RUN.
  - RUN: busy=1. Each edge, compare slice idx as unsigned N-bit values.
    - A slice < B slice -> result=100.
    - A slice > B slice -> result=001.
    - Equal slices -> result unchanged.
    - idx increments. After slice SLICES-1 is processed, go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle. start=1 here is accepted (back-to-back: RUN next, done falls). Otherwise go to IDLE.
- Slice order: LSB slice (idx 0) first. Higher slices overwrite lower results, so the final result is the MSB-dominant comparison with cascade-in as the tiebreak.
- Latency: start accepted at edge k; done high after edge k+SLICES. Throughput: one compare per SLICES+1 cycles.
- Outputs: f1/f2/f3 are registered, update only on entry to DONE, and hold through IDLE until the next DONE. They are not cleared on start.
- Cascade-in that is not one-hot (000, 110, 111, …) with all slices equal -> f=000. This matches the comparator's default case. Any unequal slice overrides invalid cascade-in.
- start while busy is ignored; ain/bin changes during RUN have no effect.
- SLICES=1 -> single RUN cycle.

Optional Feature:
- Macro SEQ_COMP_EARLY_EXIT_EN.
- Defined:
  - Slices are processed MSB-first (idx SLICES-1 down to 0).
  - RUN ends on the first unequal slice, going to DONE on that edge with result 100/001.
  - All-equal falls through to the latched cascade-in after SLICES cycles.
  - Latency varies, 1..SLICES cycles; results are identical to the fixed mode.
- Undefined: fixed LSB-first, SLICES-cycle latency as above.

Decomposition:
- Package seq_comp_pkg:
  - state enum (IDLE, RUN, DONE).
  - result encodings RES_LT=3'b100, RES_EQ=3'b010, RES_GT=3'b001, RES_NONE=3'b000.
- Sub-module slice_cmp: combinational N-bit compare returning lt/gt; instantiated once and fed by a slice mux on idx.

Test Plan (N=4, SLICES=4):
- ain=16'h1234, bin=16'h1235, cascade=010 -> done 5 cycles after start edge (4 RUN + DONE), f=100, busy high 4 cycles.
- ain=bin=16'hABCD, cascade 010 -> f=010; repeat with cascade 001 -> f=001; repeat with cascade 110 -> f=000.
- ain=16'hF000, bin=16'h0FFF -> f=001 (MSB slice overrides LSB result of 100).
- Back-to-back: start held high through DONE with 16'h0001 vs 16'h0000 then 16'h0000 vs 16'h0001 -> two done pulses 5 cycles apart, f=001 then 100; start pulses during RUN ignored.
- Assert rst for one cycle at RUN idx=2 -> busy=0, done=0, f=000 immediately (async); no done follows until a new start.
- With SEQ_COMP_EARLY_EXIT_EN: ain=16'h8000, bin=16'h7FFF -> done 1 RUN cycle after start, f=001; ain=bin -> 4 RUN cycles, cascade result.
